// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word-in / bit-out handshake bundle for bit_serializer
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_en;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  in_valid, in_data, ser_en,
    output in_ready, ser_bit, ser_valid, ser_last, busy
  );

  modport master (
    output in_valid, in_data, ser_en,
    input  in_ready, ser_bit, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to 1-bit stream serializer, zero-gap back-to-back words
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  bit_serializer_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  logic in_ready_w, ser_bit_w, ser_valid_w, ser_last_w, busy_w;
  logic accept_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    accept_w = bus.in_valid & in_ready_w;
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    if (state_q == SHIFT && bus.ser_en) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
      end
    end
    // A reload on the final bit overrides the return to IDLE, giving no bubble.
    if (accept_w) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = bus.in_data;
    end
  end

  always_comb begin
    in_ready_w  = 1'b0;
    ser_bit_w   = 1'b0;
    ser_valid_w = 1'b0;
    ser_last_w  = 1'b0;
    busy_w      = 1'b0;
    if (state_q == IDLE) begin
      in_ready_w = 1'b1;
    end else begin
      in_ready_w  = (cnt_q == LAST) && bus.ser_en;
      ser_valid_w = 1'b1;
      busy_w      = 1'b1;
      ser_last_w  = (cnt_q == LAST);
      ser_bit_w   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.ser_bit   = ser_bit_w;
  assign bus.ser_valid = ser_valid_w;
  assign bus.ser_last  = ser_last_w;
  assign bus.busy      = busy_w;
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed and random checks of MSB-first and LSB-first serializers
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vi = 1'b0;
  logic [7:0] di = 8'h00;
  logic       ei = 1'b0;

  int checks_total = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  int         m_idx = -1;
  logic [7:0] m_word = 8'h00;

  bit_serializer_if #(.WIDTH(8)) ifm ();
  bit_serializer_if #(.WIDTH(8)) ifl ();

  assign ifm.in_valid = vi;
  assign ifm.in_data  = di;
  assign ifm.ser_en   = ei;
  assign ifl.in_valid = vi;
  assign ifl.in_data  = di;
  assign ifl.ser_en   = ei;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic busy_e, last_e, ready_e, bit_m_e, bit_l_e;
    busy_e  = (m_idx >= 0);
    last_e  = (m_idx == 7);
    ready_e = (m_idx < 0) || (m_idx == 7 && ei);
    bit_m_e = busy_e ? m_word[7 - m_idx] : 1'b0;
    bit_l_e = busy_e ? m_word[m_idx] : 1'b0;
    chk({tag, "_m_ready"}, 32'(ifm.in_ready),  32'(ready_e));
    chk({tag, "_m_valid"}, 32'(ifm.ser_valid), 32'(busy_e));
    chk({tag, "_m_last"},  32'(ifm.ser_last),  32'(last_e));
    chk({tag, "_m_busy"},  32'(ifm.busy),      32'(busy_e));
    chk({tag, "_m_bit"},   32'(ifm.ser_bit),   32'(bit_m_e));
    chk({tag, "_l_ready"}, 32'(ifl.in_ready),  32'(ready_e));
    chk({tag, "_l_valid"}, 32'(ifl.ser_valid), 32'(busy_e));
    chk({tag, "_l_last"},  32'(ifl.ser_last),  32'(last_e));
    chk({tag, "_l_bit"},   32'(ifl.ser_bit),   32'(bit_l_e));
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic e);
    logic accept;
    accept = v && ((m_idx < 0) || (m_idx == 7 && e));
    if (m_idx >= 0 && e) begin
      m_idx = m_idx + 1;
      if (m_idx > 7) m_idx = -1;
    end
    if (accept) begin
      m_word = d;
      m_idx  = 0;
    end
  endtask

  // Called at posedge+1: apply inputs, check mid-cycle, advance the model on the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic e);
    vi = v;
    di = d;
    ei = e;
    #2;
    check_outputs(tag);
    @(posedge clk);
    model_edge(v, d, e);
    #1;
  endtask

  initial begin
    int held;
    #12;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("idle", 1'b0, 8'h77, 1'b1);

    // single word A5, MSB and LSB order
    step("a5_acc", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) step("a5", 1'b0, 8'h00, 1'b1);

    // back-to-back A5 then 3C with in_valid held
    step("b2b_acc", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) step("b2b_w1", 1'b1, 8'h3C, 1'b1);
    chk("b2b_second_loaded", 32'(m_word), 32'h3C);
    for (int i = 0; i < 9; i++) step("b2b_w2", 1'b0, 8'h00, 1'b1);

    // stall three cycles on bit index 3
    step("stall_acc", 1'b1, 8'hA5, 1'b1);
    held = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_idx == 3 && held < 3) begin
        held++;
        step("stall", 1'b0, 8'h00, 1'b0);
      end else begin
        step("stall", 1'b0, 8'h00, 1'b1);
      end
    end

    // FF offered throughout a 00 word is taken only on the last bit
    step("ovr_acc", 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step("ovr", 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) step("ovr_ff", 1'b0, 8'h00, 1'b1);

    // reset asserted mid-word at bit index 4
    step("rst_acc", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) step("rst_pre", 1'b0, 8'h00, 1'b1);
    vi = 1'b0;
    ei = 1'b1;
    #2;
    check_outputs("rst_bit4");
    rst_n = 1'b0;
    m_idx = -1;
    m_word = 8'h00;
    #1;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_idle", 1'b0, 8'h00, 1'b1);
    step("rst_acc2", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 9; i++) step("rst_post", 1'b0, 8'h00, 1'b1);

    // LSB-first sanity with 05
    step("lsb_acc", 1'b1, 8'h05, 1'b1);
    for (int i = 0; i < 9; i++) step("lsb", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
